// File: rtl/hdmi_tmds_pkg.sv
// Shared TMDS constants: control tokens, TERC4 table, widths and pipeline side-band record.
// Used by every lane of the HDMI transmit encoder.
package hdmi_tmds_pkg;

    localparam int SYM_W  = 10;
    localparam int DISP_W = 5;

    localparam logic [SYM_W-1:0] CTL_TOKEN_00 = 10'h354;
    localparam logic [SYM_W-1:0] CTL_TOKEN_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTL_TOKEN_10 = 10'h154;
    localparam logic [SYM_W-1:0] CTL_TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        MODE_CTL = 2'd0,
        MODE_AUX = 2'd1,
        MODE_VID = 2'd2
    } tmds_mode_e;

    // Everything that travels alongside the video byte; live marks a symbol
    // that entered the pipe after reset, so flushed slots emit 10'h000.
    typedef struct packed {
        logic       live;
        logic       vde;
        logic       ade;
        logic [3:0] aux;
        logic       c0;
        logic       c1;
    } tmds_side_t;

    localparam tmds_side_t SIDE_IDLE = '{live: 1'b0, vde: 1'b0, ade: 1'b0,
                                         aux: 4'h0, c0: 1'b0, c1: 1'b0};

    function automatic logic [SYM_W-1:0] terc4_lut(input logic [3:0] nib);
        logic [SYM_W-1:0] sym;
        case (nib)
            4'h0:    sym = 10'h29C;
            4'h1:    sym = 10'h263;
            4'h2:    sym = 10'h2E4;
            4'h3:    sym = 10'h2E2;
            4'h4:    sym = 10'h171;
            4'h5:    sym = 10'h11E;
            4'h6:    sym = 10'h18E;
            4'h7:    sym = 10'h13C;
            4'h8:    sym = 10'h2CC;
            4'h9:    sym = 10'h139;
            4'hA:    sym = 10'h19C;
            4'hB:    sym = 10'h2C6;
            4'hC:    sym = 10'h28E;
            4'hD:    sym = 10'h271;
            4'hE:    sym = 10'h163;
            default: sym = 10'h2C3;
        endcase
        return sym;
    endfunction

    function automatic logic [SYM_W-1:0] ctl_token(input logic c1, input logic c0);
        logic [SYM_W-1:0] sym;
        case ({c1, c0})
            2'b00:   sym = CTL_TOKEN_00;
            2'b01:   sym = CTL_TOKEN_01;
            2'b10:   sym = CTL_TOKEN_10;
            default: sym = CTL_TOKEN_11;
        endcase
        return sym;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// First two TMDS pipeline stages: byte register with popcount, then the
// transition-minimised q_m word with its ones/zeros counts.
module tmds_qm_stage
    import hdmi_tmds_pkg::*;
(
    input  logic       pclk,
    input  logic       rstin,
    input  logic [7:0] din,
    input  tmds_side_t side_in,
    output logic [8:0] q_m,
    output logic [3:0] n1q,
    output logic [3:0] n0q,
    output tmds_side_t side_out
);

    logic [7:0] din_s1;
    logic [3:0] n1d_s1;
    tmds_side_t side_s1;

    logic       dec1;
    logic [8:0] q_m_nx;
    logic [3:0] n1q_nx;

    always_ff @(posedge pclk) begin
        if (rstin) begin
            din_s1  <= '0;
            n1d_s1  <= '0;
            side_s1 <= SIDE_IDLE;
        end else begin
            din_s1  <= din;
            n1d_s1  <= popcount8(din);
            side_s1 <= side_in;
        end
    end

    // XNOR chain when the byte is ones-heavy, XOR chain otherwise.
    always_comb begin
        dec1      = (n1d_s1 > 4'd4) || ((n1d_s1 == 4'd4) && !din_s1[0]);
        q_m_nx    = '0;
        q_m_nx[0] = din_s1[0];
        for (int i = 1; i < 8; i++) begin
            q_m_nx[i] = dec1 ? ~(q_m_nx[i-1] ^ din_s1[i]) : (q_m_nx[i-1] ^ din_s1[i]);
        end
        q_m_nx[8] = ~dec1;
        n1q_nx    = popcount8(q_m_nx[7:0]);
    end

    always_ff @(posedge pclk) begin
        if (rstin) begin
            q_m      <= '0;
            n1q      <= '0;
            n0q      <= '0;
            side_out <= SIDE_IDLE;
        end else begin
            q_m      <= q_m_nx;
            n1q      <= n1q_nx;
            n0q      <= 4'd8 - n1q_nx;
            side_out <= side_s1;
        end
    end

endmodule

// File: rtl/tmds_chan_encoder.sv
// One TMDS lane: video 8b/10b with DC balance, TERC4 aux, or CTL tokens,
// one 10-bit symbol per pclk with a fixed 3-cycle latency.
module tmds_chan_encoder
    import hdmi_tmds_pkg::*;
#(
    parameter int CNT_W = DISP_W
) (
    input  logic             pclk,
    input  logic             rstin,
    input  logic [7:0]       din,
    input  logic [3:0]       aux,
    input  logic             c0,
    input  logic             c1,
    input  logic             vde,
    input  logic             ade,
    output logic [SYM_W-1:0] dout
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    tmds_side_t side_in;
    tmds_side_t side_s2;
    logic [8:0] q_m;
    logic [3:0] n1q;
    logic [3:0] n0q;

    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nx;
    logic signed [CNT_W-1:0] n1_s;
    logic signed [CNT_W-1:0] n0_s;
    logic signed [CNT_W-1:0] bal;
    logic [SYM_W-1:0]        vid_sym;
    logic                    dec2;
    logic                    dec3;
    logic                    cnt_pos;
    logic                    cnt_neg;
    tmds_mode_e              mode;

    always_comb begin
        side_in      = SIDE_IDLE;
        side_in.live = 1'b1;
        side_in.vde  = vde;
        side_in.ade  = ade;
        side_in.aux  = aux;
        side_in.c0   = c0;
        side_in.c1   = c1;
    end

    tmds_qm_stage u_qm (
        .pclk     (pclk),
        .rstin    (rstin),
        .din      (din),
        .side_in  (side_in),
        .q_m      (q_m),
        .n1q      (n1q),
        .n0q      (n0q),
        .side_out (side_s2)
    );

    // Video wins over aux, aux wins over control.
    always_comb begin
        if (side_s2.vde) begin
            mode = MODE_VID;
        end else if (side_s2.ade) begin
            mode = MODE_AUX;
        end else begin
            mode = MODE_CTL;
        end
    end

    // Disparity math is signed; the counts are zero-extended first.
    always_comb begin
        n1_s    = CNT_W'(n1q);
        n0_s    = CNT_W'(n0q);
        bal     = n1_s - n0_s;
        cnt_neg = cnt[CNT_W-1];
        cnt_pos = !cnt[CNT_W-1] && (cnt != '0);
        dec2    = (cnt == '0) || (n1q == n0q);
        dec3    = (cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q));
        vid_sym = '0;
        cnt_nx  = cnt;
        if (dec2) begin
            vid_sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_nx  = q_m[8] ? (cnt + bal) : (cnt - bal);
        end else if (dec3) begin
            vid_sym = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_nx  = cnt + (q_m[8] ? TWO : '0) - bal;
        end else begin
            vid_sym = {1'b0, q_m[8], q_m[7:0]};
            cnt_nx  = cnt + bal - (q_m[8] ? '0 : TWO);
        end
    end

    always_ff @(posedge pclk) begin
        if (rstin || !side_s2.live) begin
            dout <= '0;
            cnt  <= '0;
        end else begin
            case (mode)
                MODE_VID: begin
                    dout <= vid_sym;
                    cnt  <= cnt_nx;
                end
                MODE_AUX: begin
                    dout <= terc4_lut(side_s2.aux);
                    cnt  <= '0;
                end
                default: begin
                    dout <= ctl_token(side_s2.c1, side_s2.c0);
                    cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_chan_encoder.sv
// Scoreboard bench for one TMDS lane: directed symbols plus a decoded random video run.
module tb_tmds_chan_encoder;

    localparam int EW = 18;
    localparam logic [1:0] K_SYM  = 2'd0;
    localparam logic [1:0] K_VID  = 2'd1;
    localparam logic [1:0] K_SKIP = 2'd2;

    localparam logic [9:0] CTL_TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    localparam logic [9:0] TERC4 [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                          10'h171, 10'h11E, 10'h18E, 10'h13C,
                                          10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                          10'h28E, 10'h271, 10'h163, 10'h2C3};

    logic       pclk;
    logic       rstin;
    logic [7:0] din;
    logic [3:0] aux;
    logic       c0;
    logic       c1;
    logic       vde;
    logic       ade;
    logic [9:0] dout;

    // entry = {kind[17:16], cnt_chk[15], cnt_exp[14:10], val[9:0]}
    logic [EW-1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    tmds_chan_encoder dut (
        .pclk  (pclk),
        .rstin (rstin),
        .din   (din),
        .aux   (aux),
        .c0    (c0),
        .c1    (c1),
        .vde   (vde),
        .ade   (ade),
        .dout  (dout)
    );

    // ---------------- clock / reset ----------------
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish (time %0t, limit 1000000)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_true(input string nm, input logic ok, input int act);
        n_total++;
        if (ok === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL %s: offending value %0d (t=%0t)", nm, act, $time);
        end
    endtask

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] r;
        d    = s[9] ? ~s[7:0] : s[7:0];
        r    = '0;
        r[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge pclk) begin
        logic [EW-1:0]     e;
        logic signed [4:0] cv;
        #2;
        if (exp_q.size() >= 3) begin
            e  = exp_q.pop_front();
            cv = dut.cnt;
            case (e[17:16])
                K_SYM: begin
                    check("dout", dout, e[9:0]);
                    if (e[15]) check("cnt", {5'b0, cv}, {5'b0, e[14:10]});
                end
                K_VID: begin
                    check("decode", {2'b00, tmds_decode(dout)}, {2'b00, e[7:0]});
                    check_true("cnt_bound", (cv <= 5'sd10) && (cv >= -5'sd10), int'(cv));
                    check_true("not_ctl_token", (dout != CTL_TOK[0]) && (dout != CTL_TOK[1]) &&
                               (dout != CTL_TOK[2]) && (dout != CTL_TOK[3]), int'(dout));
                end
                default: ;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic v, input logic a, input logic [7:0] d,
                         input logic [3:0] x, input logic [1:0] c, input logic [EW-1:0] e);
        @(negedge pclk);
        // A reset edge wipes the two symbols still in flight.
        if (r && exp_q.size() >= 2) begin
            exp_q[exp_q.size()-1] = {K_SYM, 1'b1, 5'd0, 10'h000};
            exp_q[exp_q.size()-2] = {K_SYM, 1'b1, 5'd0, 10'h000};
        end
        rstin = r;
        vde   = v;
        ade   = a;
        din   = d;
        aux   = x;
        {c1, c0} = c;
        exp_q.push_back(e);
    endtask

    task automatic rst_cycle(input logic [7:0] d);
        drive(1'b1, 1'b1, 1'b0, d, 4'h0, 2'b00, {K_SYM, 1'b1, 5'd0, 10'h000});
    endtask

    task automatic ctl(input logic [1:0] c, input logic [9:0] sym);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, c, {K_SYM, 1'b1, 5'd0, sym});
    endtask

    task automatic vid(input logic [7:0] d, input logic [9:0] sym, input logic signed [4:0] ce);
        drive(1'b0, 1'b1, 1'b0, d, 4'h0, 2'b00, {K_SYM, 1'b1, ce, sym});
    endtask

    task automatic aux_sym(input logic [3:0] x, input logic [9:0] sym);
        drive(1'b0, 1'b0, 1'b1, 8'h00, x, 2'b00, {K_SYM, 1'b1, 5'd0, sym});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        logic [1:0] rc;
        rstin = 1'b1;
        vde   = 1'b0;
        ade   = 1'b0;
        din   = '0;
        aux   = '0;
        c0    = 1'b0;
        c1    = 1'b0;

        // Reset held with live video on the inputs.
        for (int i = 0; i < 4; i++) rst_cycle(8'hA5);

        ctl(2'b00, 10'h354);
        ctl(2'b01, 10'h0AB);
        ctl(2'b10, 10'h154);
        ctl(2'b11, 10'h2AB);

        vid(8'h00, 10'h100, -5'sd8);
        vid(8'h00, 10'h3FF,  5'sd2);
        vid(8'h00, 10'h100, -5'sd6);
        vid(8'h00, 10'h3FF,  5'sd4);
        ctl(2'b00, 10'h354);

        vid(8'hFF, 10'h200, -5'sd8);
        ctl(2'b00, 10'h354);

        vid(8'hA5, 10'h163, 5'sd0);
        vid(8'hA5, 10'h163, 5'sd0);

        vid(8'hF0, 10'h205, -5'sd4);
        vid(8'hF0, 10'h0FA, -5'sd2);
        vid(8'hF0, 10'h0FA,  5'sd0);

        for (int i = 0; i < 16; i++) aux_sym(4'(i), TERC4[i]);

        // Video and aux together: video takes priority.
        drive(1'b0, 1'b1, 1'b1, 8'h00, 4'h5, 2'b00, {K_SYM, 1'b1, -5'sd8, 10'h100});

        // Reset in the middle of a video run.
        vid(8'h00, 10'h3FF, 5'sd2);
        rst_cycle(8'h00);
        rst_cycle(8'h00);
        ctl(2'b11, 10'h2AB);
        vid(8'h00, 10'h100, -5'sd8);
        ctl(2'b01, 10'h0AB);

        // Random video with random blanking gaps, checked by decoding.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    rc = 2'($urandom_range(0, 3));
                    ctl(rc, CTL_TOK[rc]);
                end
            end
            rb = 8'($urandom_range(0, 255));
            drive(1'b0, 1'b1, 1'b0, rb, 4'h0, 2'b00, {K_VID, 1'b0, 5'd0, 2'b00, rb});
        end

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 2'b00, {K_SKIP, 1'b0, 5'd0, 10'h000});
        end
        repeat (3) @(negedge pclk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
